fifo_pop_stage: RTL and testbench

Downstream drain stage for the common-cells FIFO: pops entries over the FIFO's `empty`/`pop`/`data` interface and presents them as a registered valid/ready stream. It is used at crossbar master/slave ports.

- A two-entry skid buffer keeps full throughput.
- No combinational path exists from `ready_i` to `fifo_pop_o`.
- A wrapping handshake counter supports performance monitoring.

---
 rtl/common_cells_pkg.sv | 12 +
 rtl/beat_counter.sv | 34 +++
 rtl/fifo_pop_stage.sv | 104 ++++++++++
 tb/tb_fifo_pop_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_cells_pkg.sv
// rtl/common_cells_pkg.sv - shared types and constants for the common-cells FIFO stages
package common_cells_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pop_state_e;

    localparam int POP_OCC_WIDTH = 2;

endpackage

// File: rtl/beat_counter.sv
// rtl/beat_counter.sv - wrapping event counter with synchronous clear
module beat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fifo_pop_stage.sv
// rtl/fifo_pop_stage.sv - drains a non-fall-through FIFO into a registered valid/ready stream
module fifo_pop_stage
    import common_cells_pkg::*;
#(
    parameter type dtype     = logic [31:0],
    parameter int  CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     fifo_empty_i,
    input  dtype                     fifo_data_i,
    output logic                     fifo_pop_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output dtype                     data_o,
    output logic [POP_OCC_WIDTH-1:0] occupancy_o,
    output logic [CNT_WIDTH-1:0]     beats_o
);

    pop_state_e state_q;
    pop_state_e state_d;
    dtype       a_q;
    dtype       a_d;
    dtype       b_q;
    dtype       b_d;
    logic       fill;
    logic       hs;

    assign fill = fifo_pop_o;
    assign hs   = valid_o & ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // A always holds the older entry; B is only written when A is stalled.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (fill) begin
                        a_d     = fifo_data_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (hs && fill) begin
                        a_d = fifo_data_i;
                    end else if (hs) begin
                        state_d = EMPTY;
                    end else if (fill) begin
                        b_d     = fifo_data_i;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (hs) begin
                        a_d     = b_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Pop depends only on registered state, keeping ready_i off the pop path.
    always_comb begin
        fifo_pop_o  = !rst_i && !flush_i && !fifo_empty_i && (state_q != FULL);
        valid_o     = (state_q != EMPTY);
        data_o      = a_q;
        occupancy_o = '0;
        case (state_q)
            ONE:     occupancy_o = POP_OCC_WIDTH'(1);
            FULL:    occupancy_o = POP_OCC_WIDTH'(2);
            default: occupancy_o = '0;
        endcase
    end

    beat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_beat_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (flush_i),
        .en_i    (hs),
        .count_o (beats_o)
    );

endmodule

// File: tb/tb_fifo_pop_stage.sv
// tb/tb_fifo_pop_stage.sv - scoreboard bench for fifo_pop_stage with a queue-backed upstream FIFO
module tb_fifo_pop_stage;

    logic        clk;
    logic        rst_i;
    logic        flush_i;
    logic        fifo_empty_i;
    logic [31:0] fifo_data_i;
    logic        fifo_pop_o;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic [1:0]  occupancy_o;
    logic [3:0]  beats_o;

    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    logic [3:0]  exp_beats;
    logic        hs_s;
    int          pop_cnt;
    int          checks;
    int          errors;

    fifo_pop_stage #(
        .dtype     (logic [31:0]),
        .CNT_WIDTH (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_pop_o   (fifo_pop_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .occupancy_o  (occupancy_o),
        .beats_o      (beats_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic refresh();
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    endtask

    task automatic push(input logic [31:0] v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
        refresh();
    endtask

    // One clock: sample at negedge, score handshakes, then retire the pop after the edge.
    task automatic tick();
        logic        pop_s;
        logic [1:0]  occ_s;
        logic [31:0] exp_v;
        @(negedge clk);
        pop_s = fifo_pop_o;
        occ_s = occupancy_o;
        hs_s  = valid_o && ready_i && !flush_i && !rst_i;
        if (hs_s) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow got %0h want nothing", data_o);
            end else begin
                exp_v = exp_q.pop_front();
                if (data_o !== exp_v) begin
                    errors++;
                    $display("FAIL sb_data got %0h want %0h", data_o, exp_v);
                end
            end
            exp_beats = exp_beats + 4'd1;
        end
        if (flush_i && !rst_i) begin
            for (int i = 0; i < int'(occ_s); i++) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            exp_beats = 4'd0;
        end
        if (pop_s) pop_cnt++;
        @(posedge clk);
        #1;
        if (pop_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh();
        #1;
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d pending want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        flush_i = 1'b0;
        ready_i = 1'b0;
        push(32'hA5);
        tick();
        tick();
        checks += 5;
        if (fifo_pop_o !== 1'b0) begin errors++; $display("FAIL rst_pop got %b want 0", fifo_pop_o); end
        if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid_o); end
        if (data_o !== 32'h0) begin errors++; $display("FAIL rst_data got %0h want 0", data_o); end
        if (beats_o !== 4'd0) begin errors++; $display("FAIL rst_beats got %0d want 0", beats_o); end
        if (occupancy_o !== 2'd0) begin errors++; $display("FAIL rst_occ got %0d want 0", occupancy_o); end
        rst_i = 1'b0;
        #1;
        checks++;
        if (fifo_pop_o !== 1'b1) begin errors++; $display("FAIL release_pop got %b want 1", fifo_pop_o); end
        tick();
        checks += 3;
        if (valid_o !== 1'b1) begin errors++; $display("FAIL release_valid got %b want 1", valid_o); end
        if (data_o !== 32'hA5) begin errors++; $display("FAIL release_data got %0h want a5", data_o); end
        if (occupancy_o !== 2'd1) begin errors++; $display("FAIL release_occ got %0d want 1", occupancy_o); end
        ready_i = 1'b1;
        tick();
        checks++;
        if (beats_o !== exp_beats) begin errors++; $display("FAIL release_beats got %0d want %0d", beats_o, exp_beats); end
    endtask

    task automatic test_streaming();
        int cyc;
        int first_hs;
        int last_hs;
        int nhs;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) push(32'h10 + 32'(i));
        cyc = 0; first_hs = -1; last_hs = -1; nhs = 0;
        while (exp_q.size() != 0 && cyc < 40) begin
            tick();
            if (hs_s) begin
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                nhs++;
            end
            cyc++;
        end
        checks += 3;
        if (nhs != 8) begin errors++; $display("FAIL stream_count got %0d want 8", nhs); end
        if (last_hs - first_hs != 7) begin errors++; $display("FAIL stream_rate got %0d want 7", last_hs - first_hs); end
        if (beats_o !== 4'd8) begin errors++; $display("FAIL stream_beats got %0d want 8", beats_o); end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        pop_cnt = 0;
        for (int i = 0; i < 4; i++) push(32'h20 + 32'(i));
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (data_o !== 32'h20) begin errors++; $display("FAIL bp_stable got %0h want 20", data_o); end
        end
        checks += 3;
        if (pop_cnt != 2) begin errors++; $display("FAIL bp_pops got %0d want 2", pop_cnt); end
        if (occupancy_o !== 2'd2) begin errors++; $display("FAIL bp_occ got %0d want 2", occupancy_o); end
        if (fifo_pop_o !== 1'b0) begin errors++; $display("FAIL bp_full_pop got %b want 0", fifo_pop_o); end
        ready_i = 1'b1;
        tick();
        checks++;
        if (fifo_pop_o !== 1'b1) begin errors++; $display("FAIL bp_resume got %b want 1", fifo_pop_o); end
        drain("bp", 20);
        checks++;
        if (fifo_q.size() != 0) begin errors++; $display("FAIL bp_fifo_left got %0d want 0", fifo_q.size()); end
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h30 + 32'(i));
        tick();
        tick();
        tick();
        checks++;
        if (occupancy_o !== 2'd2) begin errors++; $display("FAIL flush_pre_occ got %0d want 2", occupancy_o); end
        ready_i = 1'b1;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks += 3;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", valid_o); end
        if (occupancy_o !== 2'd0) begin errors++; $display("FAIL flush_occ got %0d want 0", occupancy_o); end
        if (beats_o !== 4'd0) begin errors++; $display("FAIL flush_beats got %0d want 0", beats_o); end
        tick();
        checks++;
        if (data_o !== 32'h32 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_next got %0h/%b want 32/1", data_o, valid_o);
        end
        drain("flush", 20);
    endtask

    task automatic test_counter_wrap();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 17; i++) push(32'h40 + 32'(i));
        drain("wrap", 60);
        tick();
        checks++;
        if (beats_o !== 4'd1) begin errors++; $display("FAIL wrap_beats got %0d want 1", beats_o); end
    endtask

    task automatic test_reset_midstream();
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) push(32'h50 + 32'(i));
        tick();
        tick();
        checks += 2;
        if (valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", valid_o); end
        if (fifo_pop_o !== 1'b1) begin errors++; $display("FAIL mid_pre_pop got %b want 1", fifo_pop_o); end
        #1;
        rst_i = 1'b1;
        #1;
        checks += 5;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", valid_o); end
        if (fifo_pop_o !== 1'b0) begin errors++; $display("FAIL mid_pop got %b want 0", fifo_pop_o); end
        if (data_o !== 32'h0) begin errors++; $display("FAIL mid_data got %0h want 0", data_o); end
        if (occupancy_o !== 2'd0) begin errors++; $display("FAIL mid_occ got %0d want 0", occupancy_o); end
        if (beats_o !== 4'd0) begin errors++; $display("FAIL mid_beats got %0d want 0", beats_o); end
        exp_q.delete();
        fifo_q.delete();
        exp_beats = 4'd0;
        refresh();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_beats = 4'd0;
        pop_cnt   = 0;
        hs_s      = 1'b0;
        rst_i     = 1'b1;
        flush_i   = 1'b0;
        ready_i   = 1'b0;
        refresh();
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_counter_wrap();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
